aes_block_sched: RTL and testbench
==================================

AES_BLOCK_SCHED -- requirements
Module: aes_block_sched

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: number of 128-bit sensor blocks buffered; power of two, 2..16.
REQ-002 Parameter TIMEOUT, default 1023: maximum cycles spent in WAIT for aes_done.
REQ-003 Clocking is fixed: one clock, sclk; reset rst is asynchronous and active-high.
REQ-004 sclk  in  1  sole clock; all outputs registered on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 key_done  in  1  single-cycle pulse; key_in is valid in that cycle.
REQ-007 key_in  in  128  AES key.
REQ-008 data128  in  128  sensor plaintext block.
REQ-009 data128_en  in  1  single-cycle valid for data128.
REQ-010 aes_key  out  128  key presented to the AES core.
REQ-011 aes_key_load  out  1  one-cycle key-load strobe.
REQ-012 aes_din  out  128  plaintext presented to the AES core.
REQ-013 aes_start  out  1  one-cycle start strobe.
REQ-014 aes_done  in  1  one-cycle completion strobe from the AES core.
REQ-015 aes_dout  in  128  ciphertext; valid while aes_done is high.
REQ-016 cipher  out  128  last ciphertext.
REQ-017 cipher_valid  out  1  one-cycle strobe for cipher.
REQ-018 drop_cnt  out  16  saturating count of overflow drops.
REQ-019 timeout_err  out  1  sticky AES-timeout flag.
REQ-020 busy  out  1  high in any state other than WAIT_KEY and READY.

Function
REQ-021 FSM states: WAIT_KEY, LOAD_KEY, READY, ISSUE, WAIT.
REQ-022 WAIT_KEY: on key_done, latch key_in into aes_key and go to LOAD_KEY; no blocks are issued in this state.
REQ-023 LOAD_KEY: assert aes_key_load for exactly one cycle, then go to READY.
REQ-024 READY: a pending key has priority: latch it and go to LOAD_KEY. Otherwise, if the FIFO is non-empty, pop it, register the head into aes_din and go to ISSUE.
REQ-025 ISSUE: assert aes_start for exactly one cycle with aes_din stable; clear the timeout counter; go to WAIT.
REQ-026 WAIT: on aes_done, capture aes_dout into cipher, pulse cipher_valid in the next cycle and return to READY.
REQ-027 WAIT, timeout: if the counter reaches TIMEOUT without aes_done, set timeout_err, discard the block and return to READY. A late aes_done is then ignored.
REQ-028 Pending-key flag: set by key_done in LOAD_KEY, ISSUE or WAIT and by key_done in READY when not consumed. It holds the newest key_in and is cleared when consumed.
REQ-029 FIFO push: data128_en pushes data128 in any state, including WAIT_KEY.
REQ-030 FIFO full: data128_en when full with no pop in the same cycle drops the new block and increments drop_cnt. drop_cnt saturates at 16'hFFFF.
REQ-031 Push and pop in the same cycle while full both succeed; no drop.
REQ-032 Latency: data128_en in cycle N into an empty FIFO with the FSM in READY gives aes_start in cycle N+2 and aes_din equal to that block.
REQ-033 Ordering: blocks are issued to the AES core in arrival order; cipher outputs appear in the same order.
REQ-034 aes_key_load and aes_start are never high in the same cycle; aes_start is never issued before the first aes_key_load.

Reset
REQ-035 rst asserted forces, asynchronously: state WAIT_KEY, FIFO empty, pending-key cleared, timeout counter 0.
REQ-036 Output values under reset: aes_key 0, aes_key_load 0, aes_din 0, aes_start 0, cipher 0, cipher_valid 0, drop_cnt 0, timeout_err 0, busy 0.
REQ-037 Reset asserted mid-operation abandons the in-flight block without a cipher_valid. After release, aes_done is ignored until the next aes_start.

Structure
REQ-038 Shared package aes_sched_pkg holds the FSM state encoding, the BLK_W=128 constant and the drop_cnt width (16).
REQ-039 One sub-module, blk_fifo, implements the synchronous FIFO (push, pop, full, empty, count). The FSM and counters remain in aes_block_sched.

Verification
REQ-040 Key first: rst, then key_done with key_in=128'h000102..0F -> aes_key_load pulse 2 cycles later with aes_key=128'h000102..0F.
REQ-041 Single block: in READY, data128_en with data128=128'h00112233445566778899AABBCCDDEEFF at cycle N -> aes_start at N+2. Model aes_done 10 cycles later with aes_dout=128'h69C4E0D86A7B0430D8CDB78070B4C55A -> cipher equal to that value, cipher_valid one cycle after aes_done.
REQ-042 Overflow: with no key loaded, push 6 blocks (FIFO_DEPTH=4) -> drop_cnt=2. After key load, exactly the first 4 blocks are issued, in order.
REQ-043 Timeout: issue a block and withhold aes_done -> timeout_err=1 after TIMEOUT cycles, FSM returns to READY, the next queued block issues and timeout_err stays 1.
REQ-044 Key during WAIT: key_done while in WAIT -> current block completes, then aes_key_load precedes the next aes_start.
REQ-045 Mid-operation reset: assert rst in WAIT, release, then pulse aes_done -> no cipher_valid, drop_cnt=0, FSM in WAIT_KEY.

Source files
------------

// File: rtl/aes_sched_pkg.sv
// Shared constants for the AES block scheduler: block width, drop counter width,
// FSM state encoding and small helpers used by the scheduler and its FIFO.
package aes_sched_pkg;

  localparam int BLK_W  = 128;
  localparam int DROP_W = 16;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_WAIT_KEY = 3'd0;
  localparam logic [2:0] ST_LOAD_KEY = 3'd1;
  localparam logic [2:0] ST_READY    = 3'd2;
  localparam logic [2:0] ST_ISSUE    = 3'd3;
  localparam logic [2:0] ST_WAIT     = 3'd4;

  function automatic logic is_busy(input state_t st);
    return !((st == ST_WAIT_KEY) || (st == ST_READY));
  endfunction

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] val);
    return (val == {DROP_W{1'b1}}) ? val : val + DROP_W'(1);
  endfunction

endpackage

// File: rtl/aes_block_sched_blk_fifo.sv
// Synchronous FIFO of plaintext blocks; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module blk_fifo
  import aes_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [BLK_W-1:0]          din,
  output logic [BLK_W-1:0]          dout,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [BLK_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/aes_block_sched.sv
// Feeds buffered sensor blocks to an AES core one at a time, handling key loads,
// completion capture, AES timeouts and FIFO overflow accounting.
module aes_block_sched
  import aes_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic               sclk,
  input  logic               rst,
  input  logic               key_done,
  input  logic [BLK_W-1:0]   key_in,
  input  logic [BLK_W-1:0]   data128,
  input  logic               data128_en,
  output logic [BLK_W-1:0]   aes_key,
  output logic               aes_key_load,
  output logic [BLK_W-1:0]   aes_din,
  output logic               aes_start,
  input  logic               aes_done,
  input  logic [BLK_W-1:0]   aes_dout,
  output logic [BLK_W-1:0]   cipher,
  output logic               cipher_valid,
  output logic [DROP_W-1:0]  drop_cnt,
  output logic               timeout_err,
  output logic               busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t                    state;
  state_t                    next_state;
  logic                      pend_vld;
  logic [BLK_W-1:0]          pend_key;
  logic [TW-1:0]             tmo_cnt;

  logic                      fifo_full;
  logic                      fifo_empty;
  logic [BLK_W-1:0]          fifo_dout;
  logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;

  logic                      key_req;
  logic                      key_take;
  logic [BLK_W-1:0]          key_sel;
  logic                      pop;
  logic                      drop;
  logic                      done_ok;
  logic                      tmo_hit;

  blk_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sclk),
    .rst   (rst),
    .push  (data128_en),
    .pop   (pop),
    .din   (data128),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (unused_fifo_count)
  );

  // A key_done arriving in READY is taken directly, so the newest key always wins
  assign key_req  = key_done || pend_vld;
  assign key_sel  = key_done ? key_in : pend_key;
  assign key_take = ((state == ST_WAIT_KEY) && key_done) ||
                    ((state == ST_READY) && key_req);
  assign pop      = (state == ST_READY) && !key_req && !fifo_empty;
  assign drop     = data128_en && fifo_full && !pop;
  assign done_ok  = (state == ST_WAIT) && aes_done;
  assign tmo_hit  = (state == ST_WAIT) && !aes_done && (tmo_cnt == TW'(TIMEOUT - 1));

  always_comb begin
    next_state = state;
    case (state)
      ST_WAIT_KEY: if (key_done) next_state = ST_LOAD_KEY;
      ST_LOAD_KEY: next_state = ST_READY;
      ST_READY: begin
        if (key_req)          next_state = ST_LOAD_KEY;
        else if (!fifo_empty) next_state = ST_ISSUE;
      end
      ST_ISSUE:    next_state = ST_WAIT;
      ST_WAIT:     if (done_ok || tmo_hit) next_state = ST_READY;
      default:     next_state = ST_WAIT_KEY;
    endcase
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state        <= ST_WAIT_KEY;
      busy         <= 1'b0;
      pend_vld     <= 1'b0;
      tmo_cnt      <= '0;
      aes_key      <= '0;
      aes_key_load <= 1'b0;
      aes_din      <= '0;
      aes_start    <= 1'b0;
      cipher       <= '0;
      cipher_valid <= 1'b0;
      drop_cnt     <= '0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= next_state;
      busy         <= is_busy(next_state);
      aes_key_load <= (state == ST_LOAD_KEY);
      aes_start    <= pop;
      cipher_valid <= done_ok;

      if (key_take)      pend_vld <= 1'b0;
      else if (key_done) pend_vld <= 1'b1;

      if (key_take) aes_key <= key_sel;
      if (pop)      aes_din <= fifo_dout;
      if (done_ok)  cipher  <= aes_dout;

      if (state == ST_ISSUE)     tmo_cnt <= '0;
      else if (state == ST_WAIT) tmo_cnt <= tmo_cnt + TW'(1);

      if (tmo_hit) timeout_err <= 1'b1;
      if (drop)    drop_cnt    <= sat_inc(drop_cnt);
    end
  end

  // Holding register for a key that arrives while the core is occupied
  always_ff @(posedge sclk) begin
    if (key_done) pend_key <= key_in;
  end

endmodule

// File: tb/tb_aes_block_sched.sv
// Directed bench for aes_block_sched: key load, latency, overflow, timeout,
// key arrival during WAIT and mid-operation reset.
module tb_aes_block_sched;

  localparam int TMO = 20;
  localparam logic [127:0] MASK = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
  localparam logic [127:0] K1   = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] K2   = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
  localparam logic [127:0] P1   = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] C1   = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;

  logic         sclk = 1'b0;
  logic         rst = 1'b1;
  logic         key_done = 1'b0;
  logic [127:0] key_in = '0;
  logic [127:0] data128 = '0;
  logic         data128_en = 1'b0;
  logic [127:0] aes_key;
  logic         aes_key_load;
  logic [127:0] aes_din;
  logic         aes_start;
  logic         aes_done = 1'b0;
  logic [127:0] aes_dout = '0;
  logic [127:0] cipher;
  logic         cipher_valid;
  logic [15:0]  drop_cnt;
  logic         timeout_err;
  logic         busy;

  int total = 0;
  int passed = 0;

  aes_block_sched #(.FIFO_DEPTH(4), .TIMEOUT(TMO)) dut (
    .sclk(sclk), .rst(rst), .key_done(key_done), .key_in(key_in),
    .data128(data128), .data128_en(data128_en), .aes_key(aes_key),
    .aes_key_load(aes_key_load), .aes_din(aes_din), .aes_start(aes_start),
    .aes_done(aes_done), .aes_dout(aes_dout), .cipher(cipher),
    .cipher_valid(cipher_valid), .drop_cnt(drop_cnt),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 sclk = ~sclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [127:0] blk(input int i);
    return {4{32'hC0DE0000 + 32'(i)}};
  endfunction

  task automatic push(input logic [127:0] d);
    data128 = d;
    data128_en = 1'b1;
    step();
    data128_en = 1'b0;
  endtask

  task automatic wait_start(input string tag, input logic [127:0] exp);
    int n = 0;
    while (aes_start !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check({tag, "_start"}, aes_start, 1);
    check({tag, "_din"}, aes_din, exp);
    check({tag, "_noload"}, aes_key_load, 0);
  endtask

  task automatic respond(input string tag, input logic [127:0] dout, input int delay);
    for (int d = 0; d < delay; d++) step();
    aes_done = 1'b1;
    aes_dout = dout;
    step();
    aes_done = 1'b0;
    check({tag, "_cvalid"}, cipher_valid, 1);
    check({tag, "_cipher"}, cipher, dout);
  endtask

  task automatic expect_idle(input string tag, input int cycles);
    int starts = 0;
    for (int c = 0; c < cycles; c++) begin
      step();
      if (aes_start === 1'b1) starts++;
    end
    check(tag, 128'(starts), 0);
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_key", aes_key, 0);
    check("rst_load", aes_key_load, 0);
    check("rst_din", aes_din, 0);
    check("rst_start", aes_start, 0);
    check("rst_cipher", cipher, 0);
    check("rst_cvalid", cipher_valid, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    step();

    // Overflow with no key: six pushes into a depth-4 FIFO
    for (int i = 0; i < 6; i++) push(blk(i));
    check("ovf_drop", drop_cnt, 2);
    expect_idle("nokey_idle", 5);
    check("nokey_busy", busy, 0);

    // Key load: strobe two cycles after key_done
    key_in = K1;
    key_done = 1'b1;
    step();
    key_done = 1'b0;
    check("key_load_n1", aes_key_load, 0);
    check("key_busy", busy, 1);
    step();
    check("key_load_n2", aes_key_load, 1);
    check("key_value", aes_key, K1);
    check("key_nostart", aes_start, 0);
    // Push into the full FIFO on the same cycle as the first pop: no drop
    data128 = blk(4);
    data128_en = 1'b1;
    step();
    data128_en = 1'b0;
    check("pushpop_drop", drop_cnt, 2);
    for (int i = 0; i < 5; i++) begin
      wait_start($sformatf("ord%0d", i), blk(i));
      respond($sformatf("ord%0d", i), blk(i) ^ MASK, 3);
    end
    expect_idle("drained_idle", 10);

    // Single block latency and known ciphertext
    push(P1);
    check("lat_n1", aes_start, 0);
    step();
    check("lat_n2", aes_start, 1);
    check("lat_din", aes_din, P1);
    respond("single", C1, 10);
    step();
    check("single_pulse", cipher_valid, 0);

    // Timeout on the first of two queued blocks
    push(blk(10));
    push(blk(11));
    wait_start("tmo0", blk(10));
    for (int c = 0; c < TMO; c++) step();
    check("tmo_before", timeout_err, 0);
    step();
    check("tmo_set", timeout_err, 1);
    check("tmo_ready", busy, 0);
    aes_done = 1'b1;
    aes_dout = 128'hDEAD;
    step();
    aes_done = 1'b0;
    check("late_done_ignored", cipher_valid, 0);
    wait_start("tmo1", blk(11));
    respond("tmo1", blk(11) ^ MASK, 4);
    check("tmo_sticky", timeout_err, 1);

    // New key arrives while a block is in flight
    push(blk(20));
    push(blk(21));
    wait_start("kw0", blk(20));
    step();
    step();
    key_in = K2;
    key_done = 1'b1;
    step();
    key_done = 1'b0;
    respond("kw0", blk(20) ^ MASK, 3);
    check("kw_r0_start", aes_start, 0);
    step();
    check("kw_r1_load", aes_key_load, 0);
    check("kw_r1_start", aes_start, 0);
    step();
    check("kw_r2_load", aes_key_load, 1);
    check("kw_r2_key", aes_key, K2);
    check("kw_r2_start", aes_start, 0);
    step();
    wait_start("kw1", blk(21));
    respond("kw1", blk(21) ^ MASK, 2);

    // Reset while waiting on the AES core
    push(blk(30));
    wait_start("mr", blk(30));
    step();
    step();
    rst = 1'b1;
    #1;
    check("mr_async_busy", busy, 0);
    check("mr_async_din", aes_din, 0);
    check("mr_async_terr", timeout_err, 0);
    step();
    rst = 1'b0;
    step();
    step();
    aes_done = 1'b1;
    aes_dout = 128'hBEEF;
    step();
    aes_done = 1'b0;
    check("mr_cvalid", cipher_valid, 0);
    check("mr_cipher", cipher, 0);
    check("mr_drop", drop_cnt, 0);
    check("mr_busy", busy, 0);
    push(blk(31));
    expect_idle("mr_waitkey_idle", 10);
    check("mr_noload", aes_key_load, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
